// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_sized
// Description : Byte-addressable little-endian data memory, valid/ready
//               request/response, configurable wait states and error flags.
// Revision    : 1.0
// ============================================================================
module data_memory_sized #(
    parameter int DEPTH_BYTES  = 1024,
    parameter int ADDR_W       = 32,
    parameter int WAIT_STATES  = 1,
    parameter int PROTECT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        mem [DEPTH_BYTES];

    logic              accept;
    logic              commit;
    logic              cur_write;
    logic [1:0]        cur_size;
    logic              cur_unsigned;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic              err;
    logic              protected_store;
    logic              do_store;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_val;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = (state == IDLE) && req_valid;
    assign commit     = (state != RESP) && (state_next == RESP);

    // With zero wait states the commit edge is the accept edge, so the live
    // request must be used because nothing has been latched yet.
    always_comb begin
        cur_write    = lat_write;
        cur_size     = lat_size;
        cur_unsigned = lat_unsigned;
        cur_addr     = lat_addr;
        cur_wdata    = lat_wdata;
        if (state == IDLE) begin
            cur_write    = req_write;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
        end
    end

    // One extra bit on the end address keeps the range check free of wrap-around.
    assign nbytes   = 4'd1 << cur_size;
    assign end_addr = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes);
    assign err      = (cur_size == 2'b11)
                   || ((cur_size == 2'b01) && cur_addr[0])
                   || ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00))
                   || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

    assign protected_store = (PROTECT_ZERO != 0) && (cur_addr == '0);
    assign do_store        = commit && cur_write && !err && !protected_store;

    assign idx = cur_addr[IDX_W-1:0];
    assign b0  = mem[idx];
    assign b1  = mem[idx + IDX_W'(1)];
    assign b2  = mem[idx + IDX_W'(2)];
    assign b3  = mem[idx + IDX_W'(3)];

    always_comb begin
        load_val = {b3, b2, b1, b0};
        case (cur_size)
            2'b00:   load_val = cur_unsigned ? {24'b0, b0} : {{24{b0[7]}}, b0};
            2'b01:   load_val = cur_unsigned ? {16'b0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_STATES == 0) ? RESP : BUSY;
            BUSY:    if (wait_cnt == 4'd1) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                wait_cnt     <= 4'(WAIT_STATES);
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= (err || cur_write) ? 32'd0 : load_val;
                err_q   <= err;
            end else if ((state == RESP) && resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (4'(k) < nbytes) begin
                    mem[idx + IDX_W'(k)] <= cur_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_sized
// Description : Self-checking bench for data_memory_sized against a byte-array model.
// Revision    : 1.0
// ============================================================================
module tb_data_memory_sized;

    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
    logic [1:0]  z_req_size;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(WS), .PROTECT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(0), .PROTECT_ZERO(1)) dut_zero (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_size(z_req_size), .req_unsigned(z_req_unsigned), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'd0;
    endtask

    task automatic model_txn(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] er, output logic ee);
        longint n, last, val;
        n    = 1 << sz;
        last = longint'({32'b0, addr}) + n;
        ee   = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
               (sz == 2'd2 && addr % 4 != 0) || (last > DEPTH);
        er   = 32'd0;
        if (!ee) begin
            if (w) begin
                if (addr != 0)
                    for (int k = 0; k < n; k++) model[addr + k] = wd[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < n; k++) val = val + (longint'(model[addr + k]) << (8*k));
                if (!uns && n < 4 && val[8*n-1]) val = val - (64'sd1 << (8*n));
                er = val[31:0];
            end
        end
    endtask

    task automatic bus_txn(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'b1;
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
            if (lat >= 40) begin
                n_fail++;
                $display("FAIL resp_timeout: no resp_valid after %0d cycles", lat);
                break;
            end
            @(posedge clk);
            lat++;
        end
        rd = resp_rdata; e = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
        logic [31:0] er;
        logic ee;
        int lat;
        bus_txn(w, sz, uns, addr, wd, rd, e, lat);
        model_txn(w, sz, uns, addr, wd, er, ee);
        n_checks += 3;
        if (rd !== er) begin
            n_fail++;
            $display("FAIL rdata w=%0d sz=%0d a=%h: got %h expected %h", w, sz, addr, rd, er);
        end
        if (e !== ee) begin
            n_fail++;
            $display("FAIL err w=%0d sz=%0d a=%h: got %b expected %b", w, sz, addr, e, ee);
        end
        if (lat != WS + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d expected %0d", lat, WS + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_size = 0; z_req_unsigned = 0; z_req_addr = 0;
        z_req_wdata = 0; z_resp_ready = 0;
        model_clear();
        #23;
        n_checks += 2;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b %h expected 100 00000000",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        if ({z_req_ready, z_resp_valid, z_resp_err, z_resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs_zero_wait: got %b%b%b %h expected 100 00000000",
                     z_req_ready, z_resp_valid, z_resp_err, z_resp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input logic [31:0] rd, input logic e,
                       input logic [31:0] xr, input logic xe);
        n_checks++;
        if (rd !== xr || e !== xe) begin
            n_fail++;
            $display("FAIL %s: got %h/%b expected %h/%b", name, rd, e, xr, xe);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic e;
        run(1, 2'd2, 0, 32'd8, 32'hDEADBEEF, rd, e);  lit("store_word8", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd8, 32'h0, rd, e);         lit("load_word8", rd, e, 32'hDEADBEEF, 0);
        run(0, 2'd0, 0, 32'd8, 32'h0, rd, e);         lit("load_byte8_s", rd, e, 32'hFFFFFFEF, 0);
        run(0, 2'd0, 1, 32'd11, 32'h0, rd, e);        lit("load_byte11_u", rd, e, 32'h000000DE, 0);
        run(0, 2'd1, 0, 32'd10, 32'h0, rd, e);        lit("load_half10_s", rd, e, 32'hFFFFDEAD, 0);
        run(1, 2'd0, 0, 32'd9, 32'hFFFFFF5A, rd, e);  lit("store_byte9", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd8, 32'h0, rd, e);         lit("load_word8_b", rd, e, 32'hDEAD5AEF, 0);
        run(0, 2'd1, 0, 32'd3, 32'h0, rd, e);         lit("half_misalign", rd, e, 32'h0, 1);
        run(1, 2'd2, 0, 32'd6, 32'h01020304, rd, e);  lit("word_misalign", rd, e, 32'h0, 1);
        run(0, 2'd2, 0, 32'd4, 32'h0, rd, e);         lit("unchanged4", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd8, 32'h0, rd, e);         lit("unchanged8", rd, e, 32'hDEAD5AEF, 0);
        run(0, 2'd2, 0, 32'd1020, 32'h0, rd, e);      lit("last_word_ok", rd, e, 32'h0, 0);
        run(0, 2'd1, 0, 32'd1022, 32'h0, rd, e);      lit("last_half_ok", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd1022, 32'h0, rd, e);      lit("word_range", rd, e, 32'h0, 1);
        run(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, rd, e);  lit("word_wrap", rd, e, 32'h0, 1);
        run(0, 2'd3, 0, 32'd8, 32'h0, rd, e);         lit("size_illegal", rd, e, 32'h0, 1);
        run(1, 2'd2, 0, 32'd0, 32'h12345678, rd, e);  lit("store_zero", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd0, 32'h0, rd, e);         lit("load_zero", rd, e, 32'h0, 0);
    endtask

    task automatic test_hold();
        logic [31:0] er, held;
        logic ee;
        int i;
        model_txn(0, 2'd2, 0, 32'd8, 32'h0, er, ee);
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'd8;
        @(posedge clk);
        #1 req_valid = 0;
        for (i = 0; i < 20 && resp_valid !== 1'b1; i++) @(negedge clk);
        held = resp_rdata;
        n_checks++;
        if (held !== er || resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_first: got %h/%b expected %h/1", held, resp_valid, er);
        end
        for (int c = 0; c < 5; c++) begin
            req_valid = 1; req_write = 1; req_size = 2'd2; req_addr = 32'd8; req_wdata = $urandom;
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable cyc %0d: got v=%b rd=%h rdy=%b expected v=1 rd=%h rdy=0",
                         c, resp_valid, resp_rdata, req_ready, held);
            end
        end
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_addr = 32'd16; resp_ready = 1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready === 1'b1) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    req_valid = 0;
                end
            end
        end
        resp_ready = 0;
        n_checks++;
        if (first != 0 || second - first != WS + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected %0d", second - first, WS + 2);
        end
    endtask

    task automatic z_txn(input string name, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] xr);
        @(negedge clk);
        z_req_valid = 1; z_req_write = w; z_req_size = sz; z_req_unsigned = uns;
        z_req_addr = addr; z_req_wdata = wd;
        @(posedge clk);
        #1 z_req_valid = 0;
        @(negedge clk);
        n_checks++;
        if (z_resp_valid !== 1'b1 || z_resp_rdata !== xr || z_resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got v=%b rd=%h e=%b expected v=1 rd=%h e=0",
                     name, z_resp_valid, z_resp_rdata, z_resp_err, xr);
        end
        z_resp_ready = 1;
        @(posedge clk);
        #1 z_resp_ready = 0;
    endtask

    task automatic test_zero_wait();
        z_txn("zw_store", 1, 2'd2, 0, 32'd4, 32'hCAFEF00D, 32'h0);
        z_txn("zw_load_word", 0, 2'd2, 0, 32'd4, 32'h0, 32'hCAFEF00D);
        z_txn("zw_load_byte7", 0, 2'd0, 0, 32'd7, 32'h0, 32'hFFFFFFCA);
        z_txn("zw_load_half4_u", 0, 2'd1, 1, 32'd4, 32'h0, 32'h0000F00D);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic e, w, uns;
        logic [1:0] sz;
        int r;
        for (int t = 0; t < 300; t++) begin
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            sz  = (r < 9) ? 2'(r % 3) : 2'd3;
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = DEPTH - 4 + $urandom_range(0, 3);
                2:       addr = 32'd0;
                3, 4:    addr = $urandom_range(0, DEPTH - 1);
                default: addr = $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 1);
            run(w, sz, uns, addr, $urandom, rd, e);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic e;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'd2; req_addr = 32'd100; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL midop_reset: got %b%b%b %h expected 100 00000000",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        run(0, 2'd2, 0, 32'd100, 32'h0, rd, e);  lit("midop_no_store", rd, e, 32'h0, 0);
        run(0, 2'd2, 0, 32'd8, 32'h0, rd, e);    lit("midop_cleared", rd, e, 32'h0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_zero_wait();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Byte-addressable, little-endian data memory with a valid/ready request–response interface.
- Supports byte, halfword and word loads/stores, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal-size accesses.
- Memory latency is configurable through wait states. Sits in the MEM stage of the CPU as the parametrised successor of the single-cycle data memory; the stage stalls while req_ready or resp_valid is low.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; power of two, at least 4.
- ADDR_W, 32: width of req_addr.
- WAIT_STATES, 1: extra cycles spent in BUSY before the response (0..15).
- PROTECT_ZERO, 1: when 1, stores whose req_addr equals 0 are silently dropped.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low bytes used for byte/half.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  access rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - FSM goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter is 0; all memory bytes are cleared to 0.
- Reset mid-operation: any latched request is discarded, including a store not yet committed.
- FSM states: IDLE, BUSY, RESP.
  - req_ready=1 only in IDLE; resp_valid=1 only in RESP.
- IDLE:
  - When req_valid and req_ready are both 1 at a rising edge, latch write, size, unsigned, addr and wdata.
  - Load the wait counter with WAIT_STATES.
  - Go to BUSY if WAIT_STATES>0, else to RESP.
- BUSY:
  - Decrement the counter each cycle.
  - On the edge where the counter equals 1, go to RESP.
- Commit edge: the edge entering RESP.
  - Stores are written to memory on this edge.
  - Loads are captured into resp_rdata on this edge.
  - Latency: resp_valid rises exactly WAIT_STATES+1 cycles after the acceptance edge.
- RESP:
  - Hold resp_valid, resp_rdata and resp_err stable until resp_ready=1 at an edge.
  - On that edge return to IDLE.
  - A new request is not accepted on that same edge; back-to-back spacing is WAIT_STATES+2 cycles minimum.
- Error checks, evaluated on the latched request:
  - size 11 is illegal;
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]!=0 is misaligned;
  - addr + (1<<size) > DEPTH_BYTES is out of range, using full ADDR_W comparison so no wrap-around.
  - Any error: no memory change, resp_rdata=0, resp_err=1.
- Stores: write bytes addr .. addr+(1<<size)-1 from wdata[7:0], [15:8], ... in little-endian order. Other bytes are untouched.
- PROTECT_ZERO=1 and a store with addr==0: no write, resp_err=0. Loads from address 0 are unaffected.
- Loads:
  - byte/half are extended to 32 bits per req_unsigned; word ignores req_unsigned.
  - Result is {mem[a+3], mem[a+2], mem[a+1], mem[a]} for word.
- Stores respond with resp_rdata=0.
- Inputs are ignored outside IDLE. Changes to req_* while not ready have no effect.

Test Plan:
- Reset, WAIT_STATES=1: store word 0xDEADBEEF at addr 8, then load word at 8 -> resp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
- After that store: load byte at 8 signed -> 0xFFFFFFEF; load byte at 11 unsigned -> 0x000000DE; load half at 10 signed -> 0xFFFFDEAD.
- Store byte 0x5A at addr 9, then load word at 8 -> 0xDEAD5AEF (only byte 9 changed).
- Misaligned and range errors:
  - load half at addr 3 -> err=1, rdata=0;
  - store word at addr 6 -> err=1 and memory unchanged;
  - load word at 1022 with DEPTH_BYTES=1024 -> err=1;
  - size 11 -> err=1.
- PROTECT_ZERO=1: store word 0x12345678 at addr 0 -> err=0; load word at 0 -> 0x00000000.
- Handshake and reset:
  - hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout;
  - WAIT_STATES=0 -> response 1 cycle after accept;
  - assert rst_n=0 while in BUSY with a pending store -> outputs reset at once and the store is never written.
